// File: rtl/arb_out_buffer_pkg.sv
// arb_out_buffer_pkg: shared data-identifier constants and types for the
// arbiter output buffer and the RX/TDC word producers.
package arb_out_buffer_pkg;

  typedef logic [31:0] word_t;

  // Data identifiers carried in the top bits of every arbiter word
  localparam int unsigned TLU_MARK_BIT = 31;
  localparam logic [3:0]  RX_ID        = 4'b0100;
  localparam logic [3:0]  TDC_ID       = 4'b0010;

  typedef enum logic {
    ST_PASS,
    ST_HOLD
  } thr_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_TLU,
    SRC_RX,
    SRC_TDC
  } word_src_t;

  // TLU marker takes precedence over the 4-bit source identifier
  function automatic word_src_t word_src(input word_t w);
    if (w[TLU_MARK_BIT])      return SRC_TLU;
    if (w[31:28] == RX_ID)    return SRC_RX;
    if (w[31:28] == TDC_ID)   return SRC_TDC;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/arb_out_buffer_if.sv
// arb_out_buffer_if: arbiter-to-buffer write handshake.
interface arb_out_buffer_if;
  import arb_out_buffer_pkg::*;

  logic  ARB_WRITE_IN;
  word_t ARB_DATA_IN;
  logic  ARB_READY_OUT;

  modport master (output ARB_WRITE_IN, output ARB_DATA_IN, input ARB_READY_OUT);
  modport slave  (input ARB_WRITE_IN, input ARB_DATA_IN, output ARB_READY_OUT);
endinterface

// File: rtl/arb_out_buffer_mem.sv
// arb_out_buffer_mem: DEPTH x 32 circular storage with wrap-bit pointers and
// a registered occupancy. Callers must not push when full or pop when empty.
module arb_out_buffer_mem
  import arb_out_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  word_t       wdata,
  output word_t       head,
  output logic [AW:0] occupancy
);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_nxt, rd_nxt;
  word_t       mem [DEPTH];

  // Next pointers; flush discards everything stored, including a same-cycle push
  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      rd_nxt = wr_ptr;
    end else begin
      if (push) wr_nxt = wr_ptr + (AW+1)'(1);
      if (pop)  rd_nxt = rd_ptr + (AW+1)'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      occupancy <= wr_nxt - rd_nxt;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/arb_out_buffer.sv
// arb_out_buffer: elastic output stage behind the readout arbiter. Buffers
// arbiter words, forwards them to the board FIFO with NEAR_FULL hysteresis,
// and keeps drop / high-water statistics.
// Optional build macro: ARB_OUT_WORD_STATS_EN enables per-source word counters.
module arb_out_buffer
  import arb_out_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned HOLDOFF = 8,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  arb_out_buffer_if.slave  arb,
  output logic             FIFO_WRITE,
  output word_t            FIFO_DATA,
  input  logic             FIFO_FULL,
  input  logic             FIFO_NEAR_FULL,
  input  logic             FLUSH,
  input  logic             CLR_STATS,
  output logic [AW:0]      OCCUPANCY,
  output logic [AW:0]      MAX_OCC,
  output logic [15:0]      DROP_CNT,
  output logic             OVERFLOW_ERR,
  output logic [31:0]      TLU_WORD_CNT,
  output logic [31:0]      RX_WORD_CNT,
  output logic [31:0]      TDC_WORD_CNT
);

  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [7:0]  HOLD_END = 8'(HOLDOFF);

  thr_state_t state, state_nxt;
  logic [7:0] hcnt, hcnt_nxt;
  logic       ready, push, drop, pop;
  word_t      head;

  assign ready             = (OCCUPANCY != FULL_OCC) && !FLUSH;
  assign arb.ARB_READY_OUT = ready;
  assign push              = arb.ARB_WRITE_IN && ready;
  assign drop              = arb.ARB_WRITE_IN && !ready && !FLUSH;

  arb_out_buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (BUS_CLK),
    .rst       (BUS_RST),
    .push      (push),
    .pop       (pop),
    .flush     (FLUSH),
    .wdata     (arb.ARB_DATA_IN),
    .head      (head),
    .occupancy (OCCUPANCY)
  );

  // Throttle state and holdoff counter registers
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= ST_PASS;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Throttle next-state and pop decision; HOLD exits on the edge that ends
  // the HOLDOFF-th consecutive low cycle, so the first pop follows one cycle later
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    pop       = 1'b0;
    if (FLUSH) begin
      state_nxt = ST_PASS;
      hcnt_nxt  = '0;
    end else begin
      unique case (state)
        ST_PASS: begin
          if (FIFO_NEAR_FULL) state_nxt = ST_HOLD;
          else                pop = (OCCUPANCY != '0) && !FIFO_FULL;
        end
        ST_HOLD: begin
          if (FIFO_NEAR_FULL) begin
            hcnt_nxt = '0;
          end else if (hcnt + 8'd1 == HOLD_END) begin
            state_nxt = ST_PASS;
            hcnt_nxt  = '0;
          end else begin
            hcnt_nxt = hcnt + 8'd1;
          end
        end
        default: state_nxt = ST_PASS;
      endcase
    end
  end

  // Registered board-FIFO write port; data holds when idle
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      FIFO_WRITE <= 1'b0;
      FIFO_DATA  <= '0;
    end else begin
      FIFO_WRITE <= pop;
      if (pop) FIFO_DATA <= head;
    end
  end

  // Drop and high-water statistics; CLR_STATS wins over any update
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      MAX_OCC      <= '0;
      DROP_CNT     <= '0;
      OVERFLOW_ERR <= 1'b0;
    end else if (CLR_STATS) begin
      MAX_OCC      <= '0;
      DROP_CNT     <= '0;
      OVERFLOW_ERR <= 1'b0;
    end else begin
      if (OCCUPANCY > MAX_OCC)          MAX_OCC <= OCCUPANCY;
      if (drop && (DROP_CNT != '1))     DROP_CNT <= DROP_CNT + 16'd1;
      if (drop)                         OVERFLOW_ERR <= 1'b1;
    end
  end

`ifdef ARB_OUT_WORD_STATS_EN
  // Per-source counters, classified on the word leaving the buffer
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      TLU_WORD_CNT <= '0;
      RX_WORD_CNT  <= '0;
      TDC_WORD_CNT <= '0;
    end else if (CLR_STATS) begin
      TLU_WORD_CNT <= '0;
      RX_WORD_CNT  <= '0;
      TDC_WORD_CNT <= '0;
    end else if (pop) begin
      unique case (word_src(head))
        SRC_TLU: TLU_WORD_CNT <= TLU_WORD_CNT + 32'd1;
        SRC_RX:  RX_WORD_CNT  <= RX_WORD_CNT  + 32'd1;
        SRC_TDC: TDC_WORD_CNT <= TDC_WORD_CNT + 32'd1;
        default: ;
      endcase
    end
  end
`else
  assign TLU_WORD_CNT = '0;
  assign RX_WORD_CNT  = '0;
  assign TDC_WORD_CNT = '0;
`endif

endmodule

// File: tb/tb_arb_out_buffer.sv
// tb_arb_out_buffer: directed and randomized checks of arb_out_buffer against
// a queue-based reference model.
module tb_arb_out_buffer;
  import arb_out_buffer_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned HOLDOFF = 8;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST = 1'b1;
  logic        FIFO_WRITE;
  logic [31:0] FIFO_DATA;
  logic        FIFO_FULL = 1'b0, FIFO_NEAR_FULL = 1'b0, FLUSH = 1'b0, CLR_STATS = 1'b0;
  logic [4:0]  OCCUPANCY, MAX_OCC;
  logic [15:0] DROP_CNT;
  logic        OVERFLOW_ERR;
  logic [31:0] TLU_WORD_CNT, RX_WORD_CNT, TDC_WORD_CNT;

  arb_out_buffer_if arb_if ();

  arb_out_buffer #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST        (BUS_RST),
    .arb            (arb_if.slave),
    .FIFO_WRITE     (FIFO_WRITE),
    .FIFO_DATA      (FIFO_DATA),
    .FIFO_FULL      (FIFO_FULL),
    .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
    .FLUSH          (FLUSH),
    .CLR_STATS      (CLR_STATS),
    .OCCUPANCY      (OCCUPANCY),
    .MAX_OCC        (MAX_OCC),
    .DROP_CNT       (DROP_CNT),
    .OVERFLOW_ERR   (OVERFLOW_ERR),
    .TLU_WORD_CNT   (TLU_WORD_CNT),
    .RX_WORD_CNT    (RX_WORD_CNT),
    .TDC_WORD_CNT   (TDC_WORD_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_hold;
  int          m_low;
  bit          m_we;
  logic [31:0] m_data;
  int          m_max, m_drop;
  bit          m_ovf;
  logic [31:0] m_tlu, m_rx, m_tdc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hold = 0; m_low = 0; m_we = 0; m_data = '0;
    m_max = 0; m_drop = 0; m_ovf = 0;
    m_tlu = '0; m_rx = '0; m_tdc = '0;
  endtask

  task automatic check_all();
    chk("occupancy", 32'(OCCUPANCY), 32'(mq.size()));
    chk("fifo_write", 32'(FIFO_WRITE), 32'(m_we));
    chk("fifo_data", FIFO_DATA, m_data);
    chk("max_occ", 32'(MAX_OCC), 32'(m_max));
    chk("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
    chk("overflow_err", 32'(OVERFLOW_ERR), 32'(m_ovf));
    chk("tlu_cnt", TLU_WORD_CNT, m_tlu);
    chk("rx_cnt", RX_WORD_CNT, m_rx);
    chk("tdc_cnt", TDC_WORD_CNT, m_tdc);
  endtask

  // One clock cycle: drive inputs, check ready, advance model, check outputs
  task automatic step(input bit wr, input logic [31:0] d, input bit full, input bit nf,
                      input bit fl, input bit clr);
    bit rdy, push, drop, pop;
    logic [31:0] w;
    @(negedge BUS_CLK);
    arb_if.ARB_WRITE_IN = wr;
    arb_if.ARB_DATA_IN  = d;
    FIFO_FULL = full; FIFO_NEAR_FULL = nf; FLUSH = fl; CLR_STATS = clr;
    #1;
    rdy  = (mq.size() != DEPTH) && !fl;
    chk("ready", 32'(arb_if.ARB_READY_OUT), 32'(rdy));
    push = wr && rdy;
    drop = wr && !rdy && !fl;
    pop  = !m_hold && (mq.size() != 0) && !full && !nf && !fl;
    @(posedge BUS_CLK);
    #1;
    if (clr) begin
      m_max = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (mq.size() > m_max) m_max = mq.size();
      if (drop && m_drop < 65535) m_drop++;
      if (drop) m_ovf = 1;
    end
    m_we = pop;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) begin
        w = mq.pop_front();
        m_data = w;
`ifdef ARB_OUT_WORD_STATS_EN
        if (!clr) begin
          if (w[31])                 m_tlu++;
          else if (w[31:28] == 4'h4) m_rx++;
          else if (w[31:28] == 4'h2) m_tdc++;
        end
`endif
      end
      if (push) mq.push_back(d);
    end
    if (clr) begin m_tlu = '0; m_rx = '0; m_tdc = '0; end
    if (fl) begin
      m_hold = 0; m_low = 0;
    end else if (!m_hold) begin
      if (nf) m_hold = 1;
    end else if (nf) begin
      m_low = 0;
    end else begin
      m_low++;
      if (m_low == HOLDOFF) begin m_hold = 0; m_low = 0; end
    end
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    int saved_drop;
    logic [31:0] rw;
    logic [3:0]  nib;
    arb_if.ARB_WRITE_IN = 1'b0;
    arb_if.ARB_DATA_IN  = '0;
    model_reset();

    // Reset values
    #12;
    check_all();
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    #1;
    chk("ready_after_reset", 32'(arb_if.ARB_READY_OUT), 32'd1);

    // Single word latency
    step(1, 32'h40000123, 0, 0, 0, 0);
    chk("single_no_bypass", 32'(FIFO_WRITE), 32'd0);
    chk("single_occ1", 32'(OCCUPANCY), 32'd1);
    step(0, '0, 0, 0, 0, 0);
    chk("single_write", 32'(FIFO_WRITE), 32'd1);
    chk("single_data", FIFO_DATA, 32'h40000123);
    chk("single_occ0", 32'(OCCUPANCY), 32'd0);
    idle(1);
    chk("single_data_hold", FIFO_DATA, 32'h40000123);

    // Fill with board FIFO full, two drops
    for (int i = 0; i < 18; i++) step(1, 32'h100 + i, 1, 0, 0, 0);
    chk("fill_drop_cnt", 32'(DROP_CNT), 32'd2);
    chk("fill_ovf", 32'(OVERFLOW_ERR), 32'd1);
    chk("fill_max", 32'(MAX_OCC), 32'd16);
    chk("fill_ready_low", 32'(arb_if.ARB_READY_OUT), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 0, 0, 0, 0);
      chk("drain_write", 32'(FIFO_WRITE), 32'd1);
      chk("drain_order", FIFO_DATA, 32'h100 + i);
    end
    idle(1);

    // Push+pop at 15 keeps count; at 16 the write is refused and dropped
    for (int i = 0; i < 15; i++) step(1, 32'h200 + i, 1, 0, 0, 0);
    step(1, 32'h20F, 0, 0, 0, 0);
    chk("pushpop_occ15", 32'(OCCUPANCY), 32'd15);
    step(1, 32'h210, 1, 0, 0, 0);
    chk("full_occ16", 32'(OCCUPANCY), 32'd16);
    saved_drop = int'(DROP_CNT);
    step(1, 32'h211, 0, 0, 0, 0);
    chk("full_pop_drop", 32'(DROP_CNT), 32'(saved_drop + 1));
    chk("full_pop_occ", 32'(OCCUPANCY), 32'd15);
    idle(17);

    // Throttle hysteresis
    for (int i = 0; i < 3; i++) step(1, 32'h20000000 + i, 0, 1, 0, 0);
    for (int i = 0; i < HOLDOFF; i++) begin
      step(0, '0, 0, 0, 0, 0);
      chk("thr_hold", 32'(FIFO_WRITE), 32'd0);
    end
    step(0, '0, 0, 0, 0, 0);
    chk("thr_resume", 32'(FIFO_WRITE), 32'd1);
    step(1, 32'h20000010, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 0, 0, 0, 0);
      chk("thr_restart_a", 32'(FIFO_WRITE), 32'd0);
    end
    step(0, '0, 0, 1, 0, 0);
    for (int i = 0; i < HOLDOFF; i++) begin
      step(0, '0, 0, 0, 0, 0);
      chk("thr_restart_b", 32'(FIFO_WRITE), 32'd0);
    end
    step(0, '0, 0, 0, 0, 0);
    chk("thr_restart_resume", 32'(FIFO_WRITE), 32'd1);
    idle(6);

    // Flush with buffered words and a concurrent push
    for (int i = 0; i < 5; i++) step(1, 32'h300 + i, 1, 0, 0, 0);
    saved_drop = int'(DROP_CNT);
    step(1, 32'hDEAD0001, 0, 0, 1, 0);
    chk("flush_occ", 32'(OCCUPANCY), 32'd0);
    chk("flush_no_write", 32'(FIFO_WRITE), 32'd0);
    chk("flush_drop", 32'(DROP_CNT), 32'(saved_drop));
    idle(3);
    chk("flush_still_idle", 32'(FIFO_WRITE), 32'd0);

    // Per-source statistics
    step(0, '0, 0, 0, 0, 1);
    step(1, 32'h80000001, 1, 0, 0, 0);
    step(1, 32'h40000002, 1, 0, 0, 0);
    step(1, 32'h20000003, 1, 0, 0, 0);
    step(1, 32'h10000004, 1, 0, 0, 0);
    idle(5);
`ifdef ARB_OUT_WORD_STATS_EN
    chk("stats_tlu", TLU_WORD_CNT, 32'd1);
    chk("stats_rx", RX_WORD_CNT, 32'd1);
    chk("stats_tdc", TDC_WORD_CNT, 32'd1);
`else
    chk("stats_tlu_off", TLU_WORD_CNT, 32'd0);
    chk("stats_rx_off", RX_WORD_CNT, 32'd0);
    chk("stats_tdc_off", TDC_WORD_CNT, 32'd0);
`endif
    step(1, 32'h80000005, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 1);
    chk("clr_pop_write", 32'(FIFO_WRITE), 32'd1);
    chk("clr_tlu", TLU_WORD_CNT, 32'd0);
    chk("clr_drop", 32'(DROP_CNT), 32'd0);
    chk("clr_ovf", 32'(OVERFLOW_ERR), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      nib = 4'($urandom_range(0, 15));
      rw  = {nib, 28'($urandom)};
      step($urandom_range(0, 9) < 7, rw, $urandom_range(0, 9) < 2,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) step(1, 32'h400 + i, 1, 0, 0, 0);
    @(negedge BUS_CLK);
    arb_if.ARB_WRITE_IN = 1'b1;
    #2;
    BUS_RST = 1'b1;
    #1;
    model_reset();
    check_all();
    arb_if.ARB_WRITE_IN = 1'b0;
    FIFO_FULL = 0; FIFO_NEAR_FULL = 0; FLUSH = 0; CLR_STATS = 0;
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    step(1, 32'h80000077, 0, 0, 0, 0);
    idle(2);
    chk("post_reset_data", FIFO_DATA, 32'h80000077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
